rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters. It issues a one-hot grant by decoding a registered 3-bit winner index. Each grant is held until the owner signals completion, drops its request, or exceeds a hold limit. The block sits between the requesters and the shared resource's select logic. `grant` drives the enables and `grant_id` drives the mux select.

---
 rtl/rr_arbiter8.sv | 123 ++++++++++++
 tb/tb_rr_arbiter8.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered winner index, one-hot grant
// decode, owner-driven release and a per-grant hold limit.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_r;
    logic [2:0]    ptr_r;
    logic [CW-1:0] cnt_r;

    logic [2:0]    winner_s;
    logic          any_req_s;
    logic          normal_rel_s;
    logic          force_rel_s;

    // First set request bit at or after ptr, wrapping 7 -> 0.
    function automatic logic [2:0] pick_winner(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        pick_winner = p;
        found       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] decode_id(input logic [2:0] id);
        logic [7:0] one;
        one       = 8'h01;
        decode_id = one << id;
    endfunction

    // Arbitration decisions for the current cycle.
    always_comb begin
        winner_s     = pick_winner(req, ptr_r);
        any_req_s    = 1'b0;
        normal_rel_s = 1'b0;
        force_rel_s  = 1'b0;
        if (req != 8'h00) begin
            any_req_s = 1'b1;
        end else begin
            any_req_s = 1'b0;
        end
        if (done || !req[grant_id]) begin
            normal_rel_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
            force_rel_s = 1'b1;
        end else begin
            normal_rel_s = 1'b0;
            force_rel_s  = 1'b0;
        end
    end

    // Arbiter state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            cnt_r       <= '0;
            grant       <= 8'h00;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (any_req_s) begin
                        grant_id    <= winner_s;
                        grant       <= decode_id(winner_s);
                        grant_valid <= 1'b1;
                        cnt_r       <= '0;
                        state_r     <= ST_GRANT;
                    end else begin
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (normal_rel_s || force_rel_s) begin
                        // grant_id is kept so the mux select stays stable while idle.
                        ptr_r       <= grant_id + 3'd1;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                        timeout     <= force_rel_s & ~normal_rel_s;
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1'b1);
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant       <= 8'h00;
                    grant_valid <= 1'b0;
                    timeout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a behavioural model pushes expected outputs
// per clock edge, a monitor pops and compares; directed then random stimulus.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state: owner index or -1 when idle, cycles held so far.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    int   m_id    = 0;
    bit   m_to    = 1'b0;

    rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: predicts outputs after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_id = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_id    = m_owner;
                    m_held  = 1;
                end
            end
        end else if (done || !req[m_owner]) begin
            m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b0;
        end else if (m_held == HOLD) begin
            m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b1;
        end else begin
            m_held = m_held + 1; m_to = 1'b0;
        end
        e.g  = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e.id = 3'(m_id);
        e.v  = (m_owner >= 0);
        e.to = m_to;
        sb_q.push_back(e);
    end

    // Monitor: compares DUT outputs shortly after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty at %0t: no expected entry", $time);
        end else begin
            e = sb_q.pop_front();
            if ({grant, grant_id, grant_valid, timeout} !== e) begin
                n_err++;
                $display("FAIL outputs at %0t: got grant=%h id=%0d v=%b to=%b, want grant=%h id=%0d v=%b to=%b",
                         $time, grant, grant_id, grant_valid, timeout, e.g, e.id, e.v, e.to);
            end
        end
    end

    task automatic step(input logic [7:0] r, input logic d, input logic rn);
        req   = r;
        done  = d;
        rst_n = rn;
        @(negedge clk);
    endtask

    task automatic check_const(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        req = 8'h00; done = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        // Reset held with all requests asserted.
        step(8'hFF, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b0);
        check_const("reset_grant", grant, 8'h00);
        step(8'hFF, 1'b0, 1'b1);
        check_const("first_grant", grant, 8'h01);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        // Single requester, done on third grant cycle.
        step(8'h20, 1'b0, 1'b1);
        check_const("single_grant", grant, 8'h20);
        step(8'h20, 1'b0, 1'b1);
        step(8'h20, 1'b0, 1'b1);
        step(8'h20, 1'b1, 1'b1);
        check_const("single_release", grant, 8'h00);
        // Rotation with done every grant cycle.
        for (int i = 0; i < 18; i++) step(8'hFF, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        // Wrap search: grant index 6, then 0 beats 6 with ptr at 7.
        step(8'h40, 1'b0, 1'b1);
        step(8'h40, 1'b1, 1'b1);
        step(8'h41, 1'b0, 1'b1);
        check_const("wrap_search", grant, 8'h01);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        // Forced release by hold limit, then re-grant.
        step(8'h04, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h04, 1'b0, 1'b1);
        check_const("hold_last", grant, 8'h04);
        step(8'h04, 1'b0, 1'b1);
        check_const("timeout_pulse", {7'd0, timeout}, 8'h01);
        for (int i = 0; i < 6; i++) step(8'h04, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        // done together with the last allowed cycle wins over timeout.
        step(8'h04, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h04, 1'b0, 1'b1);
        step(8'h04, 1'b1, 1'b1);
        check_const("done_at_limit", {7'd0, timeout}, 8'h00);
        step(8'h00, 1'b0, 1'b1);
        // Reset in the middle of a grant.
        step(8'h08, 1'b0, 1'b1);
        check_const("mid_grant", grant, 8'h08);
        step(8'hFF, 1'b0, 1'b0);
        check_const("mid_reset", grant, 8'h00);
        step(8'hFF, 1'b0, 1'b1);
        check_const("post_reset", grant, 8'h01);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));
        end
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
